sha3_ctrl: RTL and testbench

Sequencing controller for the SHA-3 core. It accepts a message as a 64-bit AXI-Stream and XORs each word into the Keccak state lane by lane. It inserts SHA-3 padding, runs the 24-round Keccak-f[1600] permutation one round per cycle after every rate block, and streams the digest lanes out on an AXI-Stream master. It owns only sequencing; the 5x5x64 state array and round logic live in the datapath it drives.

---
 rtl/sha3_pkg.sv | 43 ++++
 rtl/sha3_pad_gen.sv | 28 ++
 rtl/sha3_ctrl.sv | 178 +++++++++++++++++
 tb/tb_sha3_ctrl.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha3_pkg.sv
// Shared types and constants for the SHA-3 sequencing controller.
package sha3_pkg;

  typedef enum logic [1:0] {
    MODE_224 = 2'd0,
    MODE_256 = 2'd1,
    MODE_384 = 2'd2,
    MODE_512 = 2'd3
  } mode_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_ABSORB,
    S_PAD_HEAD,
    S_PAD_TAIL,
    S_PERM,
    S_SQUEEZE
  } ctrl_state_t;

  localparam int         NROUNDS       = 24;
  localparam logic [7:0] PAD_HEAD_BYTE = 8'h06;
  localparam logic [7:0] PAD_TAIL_BYTE = 8'h80;

  function automatic logic [4:0] rate_lanes(input mode_t m);
    case (m)
      MODE_224: return 5'd18;
      MODE_256: return 5'd17;
      MODE_384: return 5'd13;
      default:  return 5'd9;
    endcase
  endfunction

  function automatic logic [4:0] digest_lanes(input mode_t m);
    case (m)
      MODE_224: return 5'd4;
      MODE_256: return 5'd4;
      MODE_384: return 5'd6;
      default:  return 5'd8;
    endcase
  endfunction

endpackage

// File: rtl/sha3_pad_gen.sv
// Lane index and XOR operand for the two padding cycles.
module sha3_pad_gen
  import sha3_pkg::*;
(
  input  mode_t       mode,
  input  logic [4:0]  lane_cnt,
  input  logic        phase,     // 0 = head byte, 1 = tail byte
  output logic [4:0]  lane,
  output logic [63:0] xor_data
);

  logic [4:0]  last_lane;
  logic [63:0] tail_word;

  always_comb begin
    last_lane = rate_lanes(mode) - 5'd1;
    tail_word = {PAD_TAIL_BYTE, 56'h0};
    if (phase) begin
      lane     = last_lane;
      xor_data = tail_word;
    end else begin
      // Head landing on the last rate lane carries both pad bytes at once.
      lane     = lane_cnt;
      xor_data = {56'h0, PAD_HEAD_BYTE} | ((lane_cnt == last_lane) ? tail_word : '0);
    end
  end

endmodule

// File: rtl/sha3_ctrl.sv
// SHA-3 sequencing controller: absorb, pad, permute and squeeze over an
// external Keccak state datapath.
module sha3_ctrl #(
  parameter int NROUNDS = 24,
  parameter int LANE_W  = 64
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic [LANE_W-1:0] s_tdata,
  input  logic              s_tlast,
  input  logic [1:0]        s_tid,
  output logic              st_clr,
  output logic              st_xor_en,
  output logic [4:0]        st_lane,
  output logic [LANE_W-1:0] st_xor_data,
  output logic              rnd_en,
  output logic [4:0]        rnd_idx,
  input  logic [LANE_W-1:0] st_rd_data,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [LANE_W-1:0] m_tdata,
  output logic              m_tlast,
  output logic              busy
);
  import sha3_pkg::*;

  ctrl_state_t state_q, state_d;
  mode_t       mode_q, mode_d;
  logic [4:0]  lane_q, lane_d;
  logic [4:0]  rnd_q, rnd_d;
  logic        final_q, final_d;
  logic        padn_q, padn_d;

  logic [4:0]  rate_m1, dig_m1;
  logic [4:0]  pad_lane;
  logic [63:0] pad_data;

  sha3_pad_gen u_pad_gen (
    .mode     (mode_q),
    .lane_cnt (lane_q),
    .phase    (state_q == S_PAD_TAIL),
    .lane     (pad_lane),
    .xor_data (pad_data)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_224;
      lane_q  <= '0;
      rnd_q   <= '0;
      final_q <= 1'b0;
      padn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      lane_q  <= lane_d;
      rnd_q   <= rnd_d;
      final_q <= final_d;
      padn_q  <= padn_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    lane_d      = lane_q;
    rnd_d       = rnd_q;
    final_d     = final_q;
    padn_d      = padn_q;
    s_tready    = 1'b0;
    st_clr      = 1'b0;
    st_xor_en   = 1'b0;
    st_lane     = '0;
    st_xor_data = '0;
    rnd_en      = 1'b0;
    rnd_idx     = '0;
    m_tvalid    = 1'b0;
    m_tdata     = '0;
    m_tlast     = 1'b0;
    busy        = (state_q != S_IDLE);
    rate_m1     = rate_lanes(mode_q) - 5'd1;
    dig_m1      = digest_lanes(mode_q) - 5'd1;

    case (state_q)
      S_IDLE: begin
        if (s_tvalid) begin
          mode_d  = mode_t'(s_tid);
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        st_clr  = 1'b1;
        lane_d  = '0;
        state_d = S_ABSORB;
      end
      S_ABSORB: begin
        s_tready = 1'b1;
        if (s_tvalid) begin
          st_xor_en   = 1'b1;
          st_lane     = lane_q;
          st_xor_data = s_tdata;
          if (!s_tlast) begin
            if (lane_q == rate_m1) begin
              final_d = 1'b0;
              padn_d  = 1'b0;
              state_d = S_PERM;
            end else begin
              lane_d = lane_q + 5'd1;
            end
          end else if (lane_q < rate_m1) begin
            lane_d  = lane_q + 5'd1;
            state_d = S_PAD_HEAD;
          end else begin
            // Block is full: padding goes into a fresh block after this permutation.
            final_d = 1'b0;
            padn_d  = 1'b1;
            state_d = S_PERM;
          end
        end
      end
      S_PAD_HEAD: begin
        st_xor_en   = 1'b1;
        st_lane     = pad_lane;
        st_xor_data = pad_data;
        if (lane_q == rate_m1) begin
          final_d = 1'b1;
          padn_d  = 1'b0;
          state_d = S_PERM;
        end else begin
          state_d = S_PAD_TAIL;
        end
      end
      S_PAD_TAIL: begin
        st_xor_en   = 1'b1;
        st_lane     = pad_lane;
        st_xor_data = pad_data;
        final_d     = 1'b1;
        padn_d      = 1'b0;
        state_d     = S_PERM;
      end
      S_PERM: begin
        rnd_en  = 1'b1;
        rnd_idx = rnd_q;
        if (rnd_q == 5'(NROUNDS - 1)) begin
          rnd_d  = '0;
          lane_d = '0;
          if (final_q)     state_d = S_SQUEEZE;
          else if (padn_q) state_d = S_PAD_HEAD;
          else             state_d = S_ABSORB;
        end else begin
          rnd_d = rnd_q + 5'd1;
        end
      end
      S_SQUEEZE: begin
        m_tvalid = 1'b1;
        st_lane  = lane_q;
        m_tlast  = (lane_q == dig_m1);
        if (mode_q == MODE_224 && lane_q == dig_m1)
          m_tdata = {{(LANE_W-32){1'b0}}, st_rd_data[31:0]};
        else
          m_tdata = st_rd_data;
        if (m_tready) begin
          if (lane_q == dig_m1) begin
            lane_d  = '0;
            state_d = S_IDLE;
          end else begin
            lane_d = lane_q + 5'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sha3_ctrl.sv
// Directed bench for sha3_ctrl with a lane-indexed read model of the datapath.
module tb_sha3_ctrl;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [63:0] s_tdata = '0;
  logic        s_tlast = 1'b0;
  logic [1:0]  s_tid = '0;
  logic        st_clr, st_xor_en, rnd_en, m_tvalid, m_tlast, busy;
  logic [4:0]  st_lane, rnd_idx;
  logic [63:0] st_xor_data, st_rd_data, m_tdata;
  logic        m_tready = 1'b1;

  always #5 ACLK = ~ACLK;

  sha3_ctrl #(.NROUNDS(24), .LANE_W(64)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tlast(s_tlast), .s_tid(s_tid),
    .st_clr(st_clr), .st_xor_en(st_xor_en), .st_lane(st_lane),
    .st_xor_data(st_xor_data), .rnd_en(rnd_en), .rnd_idx(rnd_idx),
    .st_rd_data(st_rd_data),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tlast(m_tlast), .busy(busy)
  );

  // Every lane reads back a distinct word with non-zero upper half.
  function automatic logic [63:0] lane_word(input logic [4:0] l);
    return {27'h5A5A5A5, l, 27'h2C2C2C2, l};
  endfunction

  assign st_rd_data = lane_word(st_lane);

  localparam logic [63:0] TAIL = 64'h8000_0000_0000_0000;

  int checks = 0;
  int errors = 0;

  logic [4:0]  xl_q[$];
  logic [63:0] xd_q[$];
  logic [4:0]  rq_q[$];
  logic [63:0] od_q[$];
  logic        ol_q[$];
  int unsigned clr_cnt = 0, cyc = 0, last_beat_cyc = 0, first_mv_cyc = 0, perm_tready = 0;
  logic        mv_prev = 1'b0;

  always @(negedge ACLK) begin
    cyc++;
    if (st_clr) clr_cnt++;
    if (st_xor_en) begin
      xl_q.push_back(st_lane);
      xd_q.push_back(st_xor_data);
    end
    if (rnd_en) begin
      rq_q.push_back(rnd_idx);
      if (s_tready) perm_tready++;
    end
    if (m_tvalid && m_tready) begin
      od_q.push_back(m_tdata);
      ol_q.push_back(m_tlast);
    end
    if (s_tvalid && s_tready && s_tlast) last_beat_cyc = cyc;
    if (m_tvalid && !mv_prev) first_mv_cyc = cyc;
    mv_prev = m_tvalid;
  end

  task automatic clear_logs();
    xl_q.delete(); xd_q.delete(); rq_q.delete(); od_q.delete(); ol_q.delete();
    clr_cnt = 0; perm_tready = 0; last_beat_cyc = 0; first_mv_cyc = 0;
  endtask

  // s_tid is inverted after the first beat; the controller must ignore it.
  task automatic send_words(input logic [1:0] tid, input int unsigned n, input logic [63:0] base);
    for (int unsigned i = 0; i < n; i++) begin
      int unsigned guard = 0;
      logic accepted = 1'b0;
      s_tvalid = 1'b1;
      s_tdata  = base + 64'(i);
      s_tlast  = (i == n - 1);
      s_tid    = (i == 0) ? tid : ~tid;
      while (!accepted && guard < 300) begin
        @(negedge ACLK);
        if (s_tready) accepted = 1'b1;
        else guard++;
      end
      if (!accepted) begin
        checks++; errors++;
        $display("FAIL send_beat%0d: s_tready=0 after %0d cycles, required 1", i, guard);
      end
      @(posedge ACLK); #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic wait_out(input int unsigned n);
    int unsigned guard = 0;
    while (od_q.size() < n && guard < 400) begin
      @(posedge ACLK); #1;
      guard++;
    end
    checks++;
    if (od_q.size() !== n) begin
      errors++;
      $display("FAIL out_count: got %0d words, required %0d", od_q.size(), n);
    end
  endtask

  task automatic test_reset();
    ARESETn = 1'b0;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    checks++;
    if ({s_tready, st_clr, st_xor_en, rnd_en, m_tvalid, m_tlast, busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 0000000",
               {s_tready, st_clr, st_xor_en, rnd_en, m_tvalid, m_tlast, busy});
    end
    checks++;
    if (st_lane !== 5'd0 || rnd_idx !== 5'd0 || st_xor_data !== 64'h0) begin
      errors++;
      $display("FAIL reset_buses: got lane=%0d rnd=%0d xor=%h, required 0", st_lane, rnd_idx, st_xor_data);
    end
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
  endtask

  task automatic test_empty_256();
    logic [4:0]  el[3] = '{5'd0, 5'd1, 5'd16};
    logic [63:0] ed[3] = '{64'h0, 64'h6, TAIL};
    clear_logs();
    send_words(2'd1, 1, 64'h0);
    wait_out(4);
    @(negedge ACLK);
    checks++;
    if (clr_cnt !== 1) begin errors++; $display("FAIL e256_clr: got %0d, required 1", clr_cnt); end
    checks++;
    if (xl_q.size() !== 3) begin
      errors++; $display("FAIL e256_xor_count: got %0d, required 3", xl_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (xl_q[i] !== el[i] || xd_q[i] !== ed[i]) begin
          errors++;
          $display("FAIL e256_xor%0d: got lane %0d data %h, required lane %0d data %h", i, xl_q[i], xd_q[i], el[i], ed[i]);
        end
      end
    end
    checks++;
    if (rq_q.size() !== 24) begin
      errors++; $display("FAIL e256_rounds: got %0d, required 24", rq_q.size());
    end else begin
      for (int i = 0; i < 24; i++) begin
        checks++;
        if (rq_q[i] !== 5'(i)) begin
          errors++; $display("FAIL e256_rnd_idx%0d: got %0d, required %0d", i, rq_q[i], i);
        end
      end
    end
    for (int i = 0; i < 4 && i < od_q.size(); i++) begin
      checks++;
      if (od_q[i] !== lane_word(5'(i)) || ol_q[i] !== (i == 3)) begin
        errors++;
        $display("FAIL e256_out%0d: got %h last %b, required %h last %b", i, od_q[i], ol_q[i], lane_word(5'(i)), (i == 3));
      end
    end
    checks++;
    if (first_mv_cyc - last_beat_cyc !== 27) begin
      errors++; $display("FAIL e256_latency: got %0d, required 27", first_mv_cyc - last_beat_cyc);
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL e256_idle: busy got %b, required 0", busy); end
  endtask

  task automatic test_512_combined_pad();
    logic [63:0] base = 64'h5120_0000_0000_0000;
    clear_logs();
    send_words(2'd3, 8, base);
    wait_out(8);
    checks++;
    if (xl_q.size() !== 9) begin
      errors++; $display("FAIL s512_xor_count: got %0d, required 9", xl_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (xl_q[i] !== 5'(i) || xd_q[i] !== base + 64'(i)) begin
          errors++; $display("FAIL s512_xor%0d: got lane %0d data %h, required lane %0d data %h", i, xl_q[i], xd_q[i], i, base + 64'(i));
        end
      end
      checks++;
      if (xl_q[8] !== 5'd8 || xd_q[8] !== 64'h8000_0000_0000_0006) begin
        errors++; $display("FAIL s512_pad: got lane %0d data %h, required lane 8 data 8000000000000006", xl_q[8], xd_q[8]);
      end
    end
    checks++;
    if (rq_q.size() !== 24) begin errors++; $display("FAIL s512_rounds: got %0d, required 24", rq_q.size()); end
    for (int i = 0; i < 8 && i < od_q.size(); i++) begin
      checks++;
      if (od_q[i] !== lane_word(5'(i)) || ol_q[i] !== (i == 7)) begin
        errors++; $display("FAIL s512_out%0d: got %h last %b, required %h last %b", i, od_q[i], ol_q[i], lane_word(5'(i)), (i == 7));
      end
    end
    checks++;
    if (first_mv_cyc - last_beat_cyc !== 26) begin
      errors++; $display("FAIL s512_latency: got %0d, required 26", first_mv_cyc - last_beat_cyc);
    end
  endtask

  task automatic test_224_exact_block();
    logic [63:0] base = 64'h2240_0000_0000_0000;
    logic [63:0] exp;
    clear_logs();
    send_words(2'd0, 18, base);
    wait_out(4);
    checks++;
    if (xl_q.size() !== 20) begin
      errors++; $display("FAIL s224_xor_count: got %0d, required 20", xl_q.size());
    end else begin
      for (int i = 0; i < 18; i++) begin
        checks++;
        if (xl_q[i] !== 5'(i) || xd_q[i] !== base + 64'(i)) begin
          errors++; $display("FAIL s224_xor%0d: got lane %0d data %h, required lane %0d data %h", i, xl_q[i], xd_q[i], i, base + 64'(i));
        end
      end
      checks++;
      if (xl_q[18] !== 5'd0 || xd_q[18] !== 64'h6) begin
        errors++; $display("FAIL s224_pad_head: got lane %0d data %h, required lane 0 data 6", xl_q[18], xd_q[18]);
      end
      checks++;
      if (xl_q[19] !== 5'd17 || xd_q[19] !== TAIL) begin
        errors++; $display("FAIL s224_pad_tail: got lane %0d data %h, required lane 17 data %h", xl_q[19], xd_q[19], TAIL);
      end
    end
    checks++;
    if (rq_q.size() !== 48) begin errors++; $display("FAIL s224_rounds: got %0d, required 48", rq_q.size()); end
    for (int i = 0; i < 4 && i < od_q.size(); i++) begin
      exp = lane_word(5'(i));
      if (i == 3) exp[63:32] = 32'h0;
      checks++;
      if (od_q[i] !== exp || ol_q[i] !== (i == 3)) begin
        errors++; $display("FAIL s224_out%0d: got %h last %b, required %h last %b", i, od_q[i], ol_q[i], exp, (i == 3));
      end
    end
    checks++;
    if (first_mv_cyc - last_beat_cyc !== 51) begin
      errors++; $display("FAIL s224_latency: got %0d, required 51", first_mv_cyc - last_beat_cyc);
    end
  endtask

  task automatic test_384_multi_block();
    logic [63:0] base = 64'h3840_0000_0000_0000;
    clear_logs();
    send_words(2'd2, 30, base);
    wait_out(6);
    checks++;
    if (xl_q.size() !== 32) begin
      errors++; $display("FAIL s384_xor_count: got %0d, required 32", xl_q.size());
    end else begin
      for (int i = 0; i < 30; i++) begin
        checks++;
        if (xl_q[i] !== 5'(i % 13) || xd_q[i] !== base + 64'(i)) begin
          errors++; $display("FAIL s384_xor%0d: got lane %0d data %h, required lane %0d data %h", i, xl_q[i], xd_q[i], i % 13, base + 64'(i));
        end
      end
      checks++;
      if (xl_q[30] !== 5'd4 || xd_q[30] !== 64'h6 || xl_q[31] !== 5'd12 || xd_q[31] !== TAIL) begin
        errors++; $display("FAIL s384_pad: got lanes %0d/%0d data %h/%h, required lanes 4/12 data 6/%h", xl_q[30], xl_q[31], xd_q[30], xd_q[31], TAIL);
      end
    end
    checks++;
    if (rq_q.size() !== 72) begin errors++; $display("FAIL s384_rounds: got %0d, required 72", rq_q.size()); end
    checks++;
    if (perm_tready !== 0) begin errors++; $display("FAIL s384_tready_in_perm: got %0d cycles, required 0", perm_tready); end
    for (int i = 0; i < 6 && i < od_q.size(); i++) begin
      checks++;
      if (od_q[i] !== lane_word(5'(i)) || ol_q[i] !== (i == 5)) begin
        errors++; $display("FAIL s384_out%0d: got %h last %b, required %h last %b", i, od_q[i], ol_q[i], lane_word(5'(i)), (i == 5));
      end
    end
  endtask

  task automatic test_backpressure();
    clear_logs();
    m_tready = 1'b0;
    send_words(2'd1, 2, 64'hB0B0_0000_0000_0000);
    for (int w = 0; w < 4; w++) begin
      int unsigned guard = 0;
      @(negedge ACLK);
      while (!m_tvalid && guard < 200) begin
        @(negedge ACLK);
        guard++;
      end
      if (!m_tvalid) begin
        checks++; errors++;
        $display("FAIL bp_wait%0d: m_tvalid=0 after %0d cycles, required 1", w, guard);
      end
      if (w == 2) begin
        for (int k = 0; k < 5; k++) begin
          checks++;
          if (m_tdata !== lane_word(5'd2) || m_tlast !== 1'b0 || m_tvalid !== 1'b1) begin
            errors++; $display("FAIL bp_hold%0d: got %h last %b valid %b, required %h last 0 valid 1", k, m_tdata, m_tlast, m_tvalid, lane_word(5'd2));
          end
          @(negedge ACLK);
        end
      end
      @(posedge ACLK); #1;
      m_tready = 1'b1;
      @(posedge ACLK); #1;
      m_tready = 1'b0;
    end
    checks++;
    if (od_q.size() !== 4) begin
      errors++; $display("FAIL bp_count: got %0d, required 4", od_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (od_q[i] !== lane_word(5'(i)) || ol_q[i] !== (i == 3)) begin
          errors++; $display("FAIL bp_out%0d: got %h last %b, required %h last %b", i, od_q[i], ol_q[i], lane_word(5'(i)), (i == 3));
        end
      end
    end
    m_tready = 1'b1;
    @(posedge ACLK); #1;
  endtask

  task automatic test_reset_mid_perm();
    int unsigned guard = 0;
    logic [63:0] base = 64'hE5E5_0000_0000_0000;
    logic [4:0]  el[4] = '{5'd0, 5'd1, 5'd2, 5'd16};
    logic [63:0] ed[4];
    ed = '{base, base + 64'd1, 64'h6, TAIL};
    clear_logs();
    send_words(2'd1, 2, 64'hDEAD_0000_0000_0000);
    @(negedge ACLK);
    while (!(rnd_en && rnd_idx == 5'd10) && guard < 200) begin
      @(negedge ACLK);
      guard++;
    end
    checks++;
    if (!(rnd_en && rnd_idx == 5'd10)) begin
      errors++; $display("FAIL rst_reach_rnd10: got rnd_en %b idx %0d, required 1/10", rnd_en, rnd_idx);
    end
    ARESETn = 1'b0;
    @(negedge ACLK);
    checks++;
    if ({s_tready, st_clr, st_xor_en, rnd_en, m_tvalid, m_tlast, busy} !== 7'b0 || rnd_idx !== 5'd0) begin
      errors++; $display("FAIL rst_mid_outputs: got flags %b rnd %0d, required 0000000 rnd 0",
                         {s_tready, st_clr, st_xor_en, rnd_en, m_tvalid, m_tlast, busy}, rnd_idx);
    end
    @(posedge ACLK); #1;
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    clear_logs();
    send_words(2'd1, 2, base);
    wait_out(4);
    checks++;
    if (clr_cnt !== 1) begin errors++; $display("FAIL rst_new_clr: got %0d, required 1", clr_cnt); end
    checks++;
    if (xl_q.size() !== 4) begin
      errors++; $display("FAIL rst_new_xor_count: got %0d, required 4", xl_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (xl_q[i] !== el[i] || xd_q[i] !== ed[i]) begin
          errors++; $display("FAIL rst_new_xor%0d: got lane %0d data %h, required lane %0d data %h", i, xl_q[i], xd_q[i], el[i], ed[i]);
        end
      end
    end
    checks++;
    if (rq_q.size() !== 24) begin errors++; $display("FAIL rst_new_rounds: got %0d, required 24", rq_q.size()); end
    for (int i = 0; i < 4 && i < od_q.size(); i++) begin
      checks++;
      if (od_q[i] !== lane_word(5'(i)) || ol_q[i] !== (i == 3)) begin
        errors++; $display("FAIL rst_new_out%0d: got %h last %b, required %h last %b", i, od_q[i], ol_q[i], lane_word(5'(i)), (i == 3));
      end
    end
  endtask

  initial begin
    test_reset();
    test_empty_256();
    test_512_combined_pad();
    test_224_exact_block();
    test_384_multi_block();
    test_backpressure();
    test_reset_mid_perm();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
